// File: rtl/isa_pkg.sv
// isa_pkg: opcode, instruction field and FSM state definitions for the operand fetch controller
package isa_pkg;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LW   = 4'd6;
   localparam logic [3:0] OP_SW   = 4'd7;
   localparam logic [3:0] OP_BEQ  = 4'd8;
   localparam logic [3:0] OP_JUMP = 4'd9;
   // immediate / jump target occupies the low byte of the instruction
   localparam int IM_W = 8;
   typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_RD3, S_MEM, S_WB, S_ISSUE} state_t;
   // ADD..SLT share the three-register read sequence
   function automatic logic is_rtype(input logic [3:0] op);
      return op <= OP_SLT;
   endfunction
endpackage

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: holds a memory request stable until ack, and aborts it after a bounded wait
module mem_port_ctrl #(
   parameter int          WORD_SIZE   = 16,
   parameter int          MEM_ADDR    = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 wr_i,
   input  logic [MEM_ADDR-1:0]  addr_i,
   input  logic [WORD_SIZE-1:0] wdata_i,
   input  logic                 ack_i,
   input  logic [WORD_SIZE-1:0] mdata_i,
   output logic                 req_o,
   output logic                 w_o,
   output logic [MEM_ADDR-1:0]  addr_o,
   output logic [WORD_SIZE-1:0] wdata_o,
   output logic                 done_o,
   output logic                 timeout_o,
   output logic                 err_o,
   output logic [WORD_SIZE-1:0] rdata_o
);
   localparam int CW = $clog2(MEM_TIMEOUT + 2);
   logic [CW-1:0] cnt_q;
   assign done_o    = req_o & ack_i;
   assign timeout_o = (MEM_TIMEOUT != 0) && req_o && !ack_i && (32'(cnt_q) == MEM_TIMEOUT - 1);
   assign rdata_o   = mdata_i;
   // request latch, wait counter and one-cycle error pulse after an abandoned request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_o   <= 1'b0;
         w_o     <= 1'b0;
         addr_o  <= '0;
         wdata_o <= '0;
         cnt_q   <= '0;
         err_o   <= 1'b0;
      end else begin
         err_o <= timeout_o;
         if (start_i) begin
            req_o   <= 1'b1;
            w_o     <= wr_i;
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            cnt_q   <= '0;
         end else if (req_o) begin
            req_o <= !(ack_i || timeout_o);
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end
endmodule

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: decodes one instruction and sequences register reads, memory access, writeback and operand issue
module operand_fetch_ctrl
   import isa_pkg::*;
#(
   parameter int          WORD_SIZE   = 16,
   parameter int          REG_ADDR    = 4,
   parameter int          OP_SIZE     = 4,
   parameter int          MEM_ADDR    = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                 DCLK,
   input  logic                 RST_N,
   input  logic [WORD_SIZE-1:0] I_IN,
   input  logic                 I_VALID,
   output logic                 I_READY,
   output logic [WORD_SIZE-1:0] DATA1_OUT,
   output logic [WORD_SIZE-1:0] DATA2_OUT,
   output logic [WORD_SIZE-1:0] DATA3_OUT,
   output logic [OP_SIZE-1:0]   SEL_OUT,
   output logic                 EX_VALID,
   input  logic                 EX_READY,
   output logic                 R_W,
   output logic [REG_ADDR-1:0]  RADDR,
   output logic [WORD_SIZE-1:0] RDATAOUT,
   input  logic [WORD_SIZE-1:0] RDATAIN,
   output logic                 M_REQ,
   output logic                 M_W,
   output logic [MEM_ADDR-1:0]  MADDR,
   output logic [WORD_SIZE-1:0] MDATAOUT,
   input  logic [WORD_SIZE-1:0] MDATAIN,
   input  logic                 M_ACK,
   output logic                 ILLEGAL,
   output logic                 ERROR
);
   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] ir_q, tmp_q, mem_rdata;
   logic [OP_SIZE-1:0]   op, op_in;
   logic [REG_ADDR-1:0]  reg1, reg2, reg3;
   logic [IM_W-1:0]      im;
   logic                 rdy_q, ill_q, accept, mem_start, mem_wr, mem_done, mem_tmo;
   assign op_in    = I_IN[WORD_SIZE-1 -: OP_SIZE];
   assign op       = ir_q[WORD_SIZE-1 -: OP_SIZE];
   assign reg1     = ir_q[WORD_SIZE-OP_SIZE-1 -: REG_ADDR];
   assign reg2     = ir_q[WORD_SIZE-OP_SIZE-REG_ADDR-1 -: REG_ADDR];
   assign reg3     = ir_q[REG_ADDR-1:0];
   assign im       = state_q == S_IDLE ? I_IN[IM_W-1:0] : ir_q[IM_W-1:0];
   assign I_READY  = rdy_q && state_q == S_IDLE;
   assign accept   = I_READY && I_VALID;
   assign EX_VALID = state_q == S_ISSUE;
   assign R_W      = state_q == S_WB;
   assign RDATAOUT = tmp_q;
   assign ILLEGAL  = ill_q;
   mem_port_ctrl #(
      .WORD_SIZE  (WORD_SIZE),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem (
      .clk      (DCLK),
      .rst_n    (RST_N),
      .start_i  (mem_start),
      .wr_i     (mem_wr),
      .addr_i   (MEM_ADDR'(im)),
      .wdata_i  (RDATAIN),
      .ack_i    (M_ACK),
      .mdata_i  (MDATAIN),
      .req_o    (M_REQ),
      .w_o      (M_W),
      .addr_o   (MADDR),
      .wdata_o  (MDATAOUT),
      .done_o   (mem_done),
      .timeout_o(mem_tmo),
      .err_o    (ERROR),
      .rdata_o  (mem_rdata)
   );
   // next state, register address and memory launch for each phase of an instruction
   always_comb begin
      state_d   = state_q;
      RADDR     = '0;
      mem_start = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_start = accept && op_in == OP_LW;
            state_d   = !accept ? S_IDLE : op_in == OP_JUMP ? S_ISSUE : op_in == OP_LW ? S_MEM :
                        op_in > OP_JUMP ? S_IDLE : S_RD1;
         end
         S_RD1: begin
            RADDR   = is_rtype(op) ? reg3 : reg1;
            state_d = S_RD2;
         end
         S_RD2: begin
            RADDR     = reg2;
            mem_start = op == OP_SW;
            mem_wr    = 1'b1;
            state_d   = op == OP_SW ? S_MEM : op == OP_ADDI ? S_WB : S_RD3;
         end
         S_RD3:   state_d = S_ISSUE;
         S_MEM:   state_d = mem_done ? (op == OP_LW ? S_WB : S_IDLE) : mem_tmo ? S_IDLE : S_MEM;
         S_WB: begin
            RADDR   = reg1;
            state_d = S_IDLE;
         end
         S_ISSUE: state_d = EX_READY ? S_IDLE : S_ISSUE;
         default: state_d = S_IDLE;
      endcase
   end
   // state, instruction/scratch registers and the issued operand bundle, loaded only when entering ISSUE
   always_ff @(posedge DCLK) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         tmp_q     <= '0;
         rdy_q     <= 1'b0;
         ill_q     <= 1'b0;
         DATA1_OUT <= '0;
         DATA2_OUT <= '0;
         DATA3_OUT <= '0;
         SEL_OUT   <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         ill_q   <= accept && op_in > OP_JUMP;
         if (accept) ir_q <= I_IN;
         if (state_q == S_RD2) tmp_q <= op == OP_ADDI ? RDATAIN + WORD_SIZE'(im) : RDATAIN;
         if (state_q == S_MEM && mem_done) tmp_q <= mem_rdata;
         if (state_q == S_RD3) begin
            DATA1_OUT <= op == OP_BEQ ? tmp_q : WORD_SIZE'(reg1);
            DATA2_OUT <= RDATAIN;
            DATA3_OUT <= op == OP_BEQ ? WORD_SIZE'(reg3) : tmp_q;
            SEL_OUT   <= op;
         end
         if (accept && op_in == OP_JUMP) begin
            DATA1_OUT <= WORD_SIZE'(im);
            DATA2_OUT <= '0;
            DATA3_OUT <= '0;
            SEL_OUT   <= op_in;
         end
      end
   end
endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// tb_operand_fetch_ctrl: directed checks of reset, R-type, BEQ, LW, SW timeout, ADDI, JUMP and illegal opcodes
module tb_operand_fetch_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] i_in = '0, data1, data2, data3, rdataout, rdatain, maddr, mdataout, mdatain = '0;
   logic [3:0]  sel, raddr;
   logic        i_valid = 1'b0, i_ready, ex_valid, ex_ready = 1'b0, r_w, m_req, m_w, m_ack = 1'b0;
   logic        illegal, error;
   logic [15:0] rf [16];
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) rdatain <= rf[raddr];

   operand_fetch_ctrl #(.MEM_TIMEOUT(4)) dut (
      .DCLK(clk), .RST_N(rst_n), .I_IN(i_in), .I_VALID(i_valid), .I_READY(i_ready),
      .DATA1_OUT(data1), .DATA2_OUT(data2), .DATA3_OUT(data3), .SEL_OUT(sel),
      .EX_VALID(ex_valid), .EX_READY(ex_ready), .R_W(r_w), .RADDR(raddr),
      .RDATAOUT(rdataout), .RDATAIN(rdatain), .M_REQ(m_req), .M_W(m_w), .MADDR(maddr),
      .MDATAOUT(mdataout), .MDATAIN(mdatain), .M_ACK(m_ack), .ILLEGAL(illegal), .ERROR(error)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_addi(input logic [15:0] r4, input logic [15:0] exp);
      rf[4] = r4;
      i_in = 16'h5420; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("addi_raddr_rd", raddr, 4);
      step; step;
      check("addi_rw", r_w, 1);
      check("addi_raddr_wb", raddr, 4);
      check("addi_wdata", rdataout, exp);
      step;
      check("addi_rw_drop", r_w, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = '0;
      rf[2] = 16'h0011; rf[3] = 16'h0022; rf[4] = 16'h00F0; rf[7] = 16'h1234;
      step; step;
      check("rst_iready", i_ready, 0);
      check("rst_exvalid", ex_valid, 0);
      check("rst_rw", r_w, 0);
      check("rst_mreq", m_req, 0);
      check("rst_illegal", illegal, 0);
      check("rst_error", error, 0);
      check("rst_data1", data1, 0);
      check("rst_sel", sel, 0);
      check("rst_maddr", maddr, 0);
      rst_n = 1'b1;
      step;
      check("rel_iready", i_ready, 1);
      // ADD r1, r2, r3
      i_in = 16'h0123; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("add_raddr3", raddr, 3);
      check("add_rw", r_w, 0);
      check("add_iready", i_ready, 0);
      step;
      check("add_raddr2", raddr, 2);
      step;
      check("add_exv_early", ex_valid, 0);
      step;
      check("add_exvalid", ex_valid, 1);
      check("add_data1", data1, 16'h0001);
      check("add_data2", data2, 16'h0011);
      check("add_data3", data3, 16'h0022);
      check("add_sel", sel, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         check("add_hold_exv", ex_valid, 1);
         check("add_hold_d2", data2, 16'h0011);
         check("add_hold_d3", data3, 16'h0022);
      end
      ex_ready = 1'b1;
      step; ex_ready = 1'b0;
      check("add_done_exv", ex_valid, 0);
      check("add_done_iready", i_ready, 1);
      check("add_retain_d3", data3, 16'h0022);
      // BEQ r2, r3, 4
      i_in = 16'h8234; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("beq_raddr1", raddr, 2);
      step;
      check("beq_raddr2", raddr, 3);
      step; step;
      check("beq_exvalid", ex_valid, 1);
      check("beq_data1", data1, 16'h0011);
      check("beq_data2", data2, 16'h0022);
      check("beq_data3", data3, 16'h0004);
      check("beq_sel", sel, 8);
      ex_ready = 1'b1;
      step; ex_ready = 1'b0;
      check("beq_done_exv", ex_valid, 0);
      // LW r5, 0x40
      i_in = 16'h6540; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("lw_mreq", m_req, 1);
      check("lw_mw", m_w, 0);
      check("lw_maddr", maddr, 16'h0040);
      step;
      check("lw_mreq2", m_req, 1);
      check("lw_exvalid", ex_valid, 0);
      m_ack = 1'b1; mdatain = 16'hBEEF;
      step; m_ack = 1'b0; mdatain = '0;
      check("lw_rw", r_w, 1);
      check("lw_raddr", raddr, 5);
      check("lw_wdata", rdataout, 16'hBEEF);
      check("lw_mreq_drop", m_req, 0);
      check("lw_exvalid_wb", ex_valid, 0);
      step;
      check("lw_rw_drop", r_w, 0);
      check("lw_iready", i_ready, 1);
      // SW r7, 0x10 with no ack
      i_in = 16'h7710; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("sw_raddr", raddr, 7);
      step; step;
      check("sw_mreq", m_req, 1);
      check("sw_mw", m_w, 1);
      check("sw_maddr", maddr, 16'h0010);
      check("sw_mdata", mdataout, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         step;
         check("sw_mreq_hold", m_req, 1);
         check("sw_err_quiet", error, 0);
      end
      step;
      check("sw_mreq_drop", m_req, 0);
      check("sw_error", error, 1);
      check("sw_iready", i_ready, 1);
      check("sw_rw", r_w, 0);
      step;
      check("sw_error_pulse", error, 0);
      // ADDI r4, 0x20 plain and wrapping
      run_addi(16'h00F0, 16'h0110);
      run_addi(16'hFFF0, 16'h0010);
      // JUMP 0xAB
      i_in = 16'h90AB; i_valid = 1'b1; ex_ready = 1'b1;
      step; i_valid = 1'b0;
      check("jmp_exvalid", ex_valid, 1);
      check("jmp_data1", data1, 16'h00AB);
      check("jmp_data2", data2, 0);
      check("jmp_data3", data3, 0);
      check("jmp_sel", sel, 9);
      step; ex_ready = 1'b0;
      check("jmp_done_exv", ex_valid, 0);
      check("jmp_retain_d1", data1, 16'h00AB);
      // illegal opcode 0xF
      i_in = 16'hF000; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("ill_pulse", illegal, 1);
      check("ill_rw", r_w, 0);
      check("ill_mreq", m_req, 0);
      check("ill_exvalid", ex_valid, 0);
      check("ill_iready", i_ready, 1);
      step;
      check("ill_pulse_end", illegal, 0);
      // reset during MEM
      i_in = 16'h6540; i_valid = 1'b1;
      step; i_valid = 1'b0;
      check("rmem_mreq", m_req, 1);
      rst_n = 1'b0;
      step;
      check("rmem_mreq_drop", m_req, 0);
      check("rmem_iready", i_ready, 0);
      check("rmem_data1", data1, 0);
      rst_n = 1'b1;
      step;
      check("rmem_iready_rel", i_ready, 1);
      check("rmem_mreq_idle", m_req, 0);
      check("rmem_rw", r_w, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
